// File: rtl/rv32i_wb_stage.sv
// Memory/writeback pipeline: registers the execute bundle (M), aligns and extends
// load data, and drives the register-file write port plus forwarding/hazard info (W).
module rv32i_wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic [4:0]      ex_rd,
    input  logic            ex_wb_en,
    input  logic            ex_is_load,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            kill,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            load_use_hazard,
    output logic            wb_enable,
    output logic [4:0]      wb_reg,
    output logic [XLEN-1:0] wb_data,
    output logic            misalign_err,
    output logic [63:0]     instret
);

    logic            m_valid_r;
    logic [4:0]      m_rd_r;
    logic            m_wb_en_r;
    logic            m_is_load_r;
    logic [2:0]      m_funct3_r;
    logic [XLEN-1:0] m_result_r;

    logic            wb_enable_r;
    logic [4:0]      wb_reg_r;
    logic [XLEN-1:0] wb_data_r;
    logic            misalign_err_r;
    logic [63:0]     instret_r;

    logic [32:0]     ext_s;
    logic            fault_s;
    logic            retire_s;
    logic [XLEN-1:0] sel_data_s;
    logic            fwd_valid_s;
    logic            hazard_s;

    // Returns {fault, data}; fault covers both misalignment and unknown width codes.
    function automatic logic [32:0] load_extract(input logic [2:0]  funct3,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] rdata);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [32:0] res_v;
        case (lane)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = lane[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            3'b000:  res_v = {1'b0, {24{byte_v[7]}}, byte_v};
            3'b100:  res_v = {1'b0, 24'd0, byte_v};
            3'b001:  res_v = {lane[0], {16{half_v[15]}}, half_v};
            3'b101:  res_v = {lane[0], 16'd0, half_v};
            3'b010:  res_v = {(lane != 2'd0), rdata};
            default: res_v = {1'b1, 32'd0};
        endcase
        return res_v;
    endfunction

    // Stage-M load extraction, result selection, forwarding and hazard detection.
    always_comb begin
        ext_s       = load_extract(m_funct3_r, m_result_r[1:0], mem_rdata);
        fault_s     = m_valid_r & m_is_load_r & ext_s[32];
        retire_s    = m_valid_r & ~kill & ~fault_s;
        sel_data_s  = m_is_load_r ? ext_s[31:0] : m_result_r;
        fwd_valid_s = m_valid_r & m_wb_en_r & ~m_is_load_r & (m_rd_r != 5'd0);
        hazard_s    = m_valid_r & m_is_load_r & m_wb_en_r & (m_rd_r != 5'd0) &
                      ((m_rd_r == id_rs1) | (m_rd_r == id_rs2));
    end

    // Stage-M registers; kill only suppresses the effects of the bundle already held here.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_r   <= 1'b0;
            m_rd_r      <= 5'd0;
            m_wb_en_r   <= 1'b0;
            m_is_load_r <= 1'b0;
            m_funct3_r  <= 3'd0;
            m_result_r  <= '0;
        end else begin
            m_valid_r   <= ex_valid;
            m_rd_r      <= ex_rd;
            m_wb_en_r   <= ex_wb_en;
            m_is_load_r <= ex_is_load;
            m_funct3_r  <= ex_funct3;
            m_result_r  <= ex_result;
        end
    end

    // Stage-W registers feeding the register-file write port and fault pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_enable_r    <= 1'b0;
            wb_reg_r       <= 5'd0;
            wb_data_r      <= '0;
            misalign_err_r <= 1'b0;
        end else begin
            wb_enable_r    <= retire_s & m_wb_en_r & (m_rd_r != 5'd0);
            wb_reg_r       <= m_rd_r;
            wb_data_r      <= sel_data_s;
            misalign_err_r <= m_valid_r & ~kill & fault_s;
        end
    end

    // Retired-instruction counter; writes to x0 still count, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            instret_r <= 64'd0;
        end else if (retire_s) begin
            instret_r <= instret_r + 64'd1;
        end else begin
            instret_r <= instret_r;
        end
    end

    assign fwd_valid       = fwd_valid_s;
    assign fwd_rd          = m_rd_r;
    assign fwd_data        = m_result_r;
    assign load_use_hazard = hazard_s;
    assign wb_enable       = wb_enable_r;
    assign wb_reg          = wb_reg_r;
    assign wb_data         = wb_data_r;
    assign misalign_err    = misalign_err_r;
    assign instret         = instret_r;

endmodule

// File: tb/tb_rv32i_wb_stage.sv
// Self-checking bench: directed load/ALU/kill/reset cases pinned by literals, then
// randomized traffic checked every cycle against an instruction-level model.
module tb_rv32i_wb_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic [4:0]  ex_rd = 5'd0;
    logic        ex_wb_en = 1'b0;
    logic        ex_is_load = 1'b0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [31:0] ex_result = 32'd0;
    logic [31:0] mem_rdata = 32'd0;
    logic        kill = 1'b0;
    logic [4:0]  id_rs1 = 5'd0;
    logic [4:0]  id_rs2 = 5'd0;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        load_use_hazard;
    logic        wb_enable;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        misalign_err;
    logic [63:0] instret;

    rv32i_wb_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load), .ex_funct3(ex_funct3),
        .ex_result(ex_result), .mem_rdata(mem_rdata), .kill(kill),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .load_use_hazard(load_use_hazard), .wb_enable(wb_enable),
        .wb_reg(wb_reg), .wb_data(wb_data), .misalign_err(misalign_err), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        bit [4:0]    rd;
        bit          wb_en;
        bit          is_load;
        bit [2:0]    f3;
        bit [31:0]   result;
    } instr_t;

    instr_t          m_inst;
    bit              e_wb_en, e_mis, e_data_known, live;
    bit [4:0]        e_wb_reg;
    bit [31:0]       e_wb_data;
    longint unsigned e_ret;
    int              vectors = 0;
    int              errors = 0;
    int              n_ret = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level view of what one clock edge does to the pipeline.
    task automatic model_update();
        int          size;
        bit          legal, aligned, fault, retire;
        bit [31:0]   val;
        if (reset) begin
            e_wb_en = 1'b0; e_mis = 1'b0; e_wb_reg = 5'd0; e_wb_data = 32'd0;
            e_ret = 0; e_data_known = 1'b1;
        end else begin
            legal   = !(m_inst.f3 == 3'd3 || m_inst.f3 == 3'd6 || m_inst.f3 == 3'd7);
            size    = 1 << m_inst.f3[1:0];
            aligned = (m_inst.result % size) == 0;
            fault   = m_inst.valid && m_inst.is_load && !(legal && aligned);
            val     = mem_rdata >> (8 * (m_inst.result % 4));
            if (size == 1) val = m_inst.f3[2] ? {24'd0, val[7:0]} : {{24{val[7]}}, val[7:0]};
            if (size == 2) val = m_inst.f3[2] ? {16'd0, val[15:0]} : {{16{val[15]}}, val[15:0]};
            retire    = m_inst.valid && !kill && !fault;
            e_wb_en   = retire && m_inst.wb_en && (m_inst.rd != 5'd0);
            e_mis     = m_inst.valid && !kill && fault;
            e_wb_reg  = m_inst.rd;
            e_wb_data = m_inst.is_load ? val : m_inst.result;
            e_data_known = e_wb_en;
            if (retire) e_ret++;
        end
        m_inst.valid   = ex_valid && !reset;
        m_inst.rd      = ex_rd;
        m_inst.wb_en   = ex_wb_en;
        m_inst.is_load = ex_is_load;
        m_inst.f3      = ex_funct3;
        m_inst.result  = ex_result;
        live = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Per-cycle comparison of every meaningful DUT output against the model.
    task automatic sample();
        bit exp_fwd, exp_haz;
        @(negedge clk);
        if (live) begin
            exp_fwd = m_inst.valid && m_inst.wb_en && !m_inst.is_load && (m_inst.rd != 5'd0);
            exp_haz = m_inst.valid && m_inst.is_load && m_inst.wb_en && (m_inst.rd != 5'd0) &&
                      (m_inst.rd == id_rs1 || m_inst.rd == id_rs2);
            chk("wb_enable", {63'd0, wb_enable}, {63'd0, e_wb_en});
            chk("misalign_err", {63'd0, misalign_err}, {63'd0, e_mis});
            chk("instret", instret, e_ret);
            chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, exp_fwd});
            chk("load_use_hazard", {63'd0, load_use_hazard}, {63'd0, exp_haz});
            if (exp_fwd) begin
                chk("fwd_rd", {59'd0, fwd_rd}, {59'd0, m_inst.rd});
                chk("fwd_data", {32'd0, fwd_data}, {32'd0, m_inst.result});
            end
            if (e_data_known) begin
                chk("wb_reg", {59'd0, wb_reg}, {59'd0, e_wb_reg});
                chk("wb_data", {32'd0, wb_data}, {32'd0, e_wb_data});
            end
        end
    endtask

    task automatic issue(input bit v, input bit [4:0] rd, input bit we, input bit ld,
                         input bit [2:0] f3, input bit [31:0] res);
        ex_valid = v; ex_rd = rd; ex_wb_en = we; ex_is_load = ld;
        ex_funct3 = f3; ex_result = res;
    endtask

    task automatic idle();
        issue(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    // Load through M and W; wb_* checked against hand-computed literals.
    task automatic do_load(input string name, input bit [2:0] f3, input bit [31:0] addr,
                           input bit [31:0] rdata, input bit exp_en, input bit [31:0] exp_data,
                           input bit exp_mis);
        issue(1'b1, 5'd9, 1'b1, 1'b1, f3, addr);
        sample(); tick();
        idle(); mem_rdata = rdata;
        sample(); tick();
        mem_rdata = 32'd0;
        sample();
        chk({name, "_en"}, {63'd0, wb_enable}, {63'd0, exp_en});
        chk({name, "_mis"}, {63'd0, misalign_err}, {63'd0, exp_mis});
        chk({name, "_ret"}, instret, 64'(n_ret));
        if (exp_en) chk({name, "_data"}, {32'd0, wb_data}, {32'd0, exp_data});
        tick();
        sample();
        chk({name, "_mis_pulse"}, {63'd0, misalign_err}, 64'd0);
        tick();
    endtask

    initial begin
        tick();
        sample();
        chk("rst_wb_enable", {63'd0, wb_enable}, 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_wb_data", {32'd0, wb_data}, 64'd0);
        tick();
        reset = 1'b0;

        n_ret = 1; do_load("lb",  3'b000, 32'h0000_1003, 32'h80FF_1234, 1'b1, 32'hFFFF_FF80, 1'b0);
        n_ret = 2; do_load("lbu", 3'b100, 32'h0000_1003, 32'h80FF_1234, 1'b1, 32'h0000_0080, 1'b0);
        n_ret = 3; do_load("lhu", 3'b101, 32'h0000_2002, 32'hBEEF_0000, 1'b1, 32'h0000_BEEF, 1'b0);
        n_ret = 4; do_load("lh",  3'b001, 32'h0000_2002, 32'hBEEF_0000, 1'b1, 32'hFFFF_BEEF, 1'b0);
        do_load("lw_mis",  3'b010, 32'h0000_3001, 32'h1234_5678, 1'b0, 32'd0, 1'b1);
        do_load("f3_011",  3'b011, 32'h0000_3000, 32'h1234_5678, 1'b0, 32'd0, 1'b1);

        issue(1'b1, 5'd0, 1'b1, 1'b0, 3'd0, 32'h0000_1234);
        sample(); tick();
        idle(); sample();
        chk("x0_fwd_valid", {63'd0, fwd_valid}, 64'd0);
        tick(); sample();
        chk("x0_wb_enable", {63'd0, wb_enable}, 64'd0);
        chk("x0_instret", instret, 64'd5);
        tick();

        issue(1'b1, 5'd5, 1'b1, 1'b0, 3'd0, 32'hAAAA_0005);
        sample(); tick();
        issue(1'b1, 5'd6, 1'b1, 1'b0, 3'd0, 32'hBBBB_0006);
        sample();
        chk("b2b_fwd_rd", {59'd0, fwd_rd}, 64'd5);
        chk("b2b_fwd_data", {32'd0, fwd_data}, 64'hAAAA_0005);
        tick(); idle(); sample();
        chk("b2b_x5", {26'd0, wb_enable, wb_reg, wb_data}, {26'd0, 1'b1, 5'd5, 32'hAAAA_0005});
        tick(); sample();
        chk("b2b_x6", {26'd0, wb_enable, wb_reg, wb_data}, {26'd0, 1'b1, 5'd6, 32'hBBBB_0006});
        chk("b2b_instret", instret, 64'd7);
        tick();

        id_rs2 = 5'd7;
        issue(1'b1, 5'd7, 1'b1, 1'b1, 3'b010, 32'h0000_0100);
        sample(); tick();
        idle(); mem_rdata = 32'hCAFE_F00D; sample();
        chk("hazard", {63'd0, load_use_hazard}, 64'd1);
        tick(); sample();
        chk("hazard_ld_data", {32'd0, wb_data}, 64'hCAFE_F00D);
        chk("hazard_ld_ret", instret, 64'd8);
        tick();
        issue(1'b1, 5'd7, 1'b1, 1'b1, 3'b010, 32'h0000_0100);
        sample(); tick();
        idle(); kill = 1'b1; sample();
        chk("kill_hazard", {63'd0, load_use_hazard}, 64'd1);
        tick(); kill = 1'b0; sample();
        chk("kill_wb_enable", {63'd0, wb_enable}, 64'd0);
        chk("kill_instret", instret, 64'd8);
        tick();
        issue(1'b1, 5'd7, 1'b1, 1'b1, 3'b010, 32'h0000_0101);
        sample(); tick();
        idle(); kill = 1'b1; sample(); tick();
        kill = 1'b0; sample();
        chk("kill_fault_mis", {63'd0, misalign_err}, 64'd0);
        tick();
        id_rs2 = 5'd0;

        issue(1'b1, 5'd10, 1'b1, 1'b0, 3'd0, 32'h0000_000A);
        sample(); tick();
        issue(1'b1, 5'd11, 1'b1, 1'b0, 3'd0, 32'h0000_000B); reset = 1'b1;
        sample(); tick();
        reset = 1'b0; idle(); sample();
        chk("midrst_outs", {61'd0, wb_enable, misalign_err, fwd_valid}, 64'd0);
        chk("midrst_instret", instret, 64'd0);
        tick(); sample();
        chk("midrst_nowrite", {63'd0, wb_enable}, 64'd0);
        issue(1'b1, 5'd12, 1'b1, 1'b0, 3'd0, 32'h0000_000C);
        tick(); idle(); sample(); tick(); sample();
        chk("postrst_write", {26'd0, wb_enable, wb_reg, wb_data}, {26'd0, 1'b1, 5'd12, 32'h0000_000C});
        chk("postrst_instret", instret, 64'd1);
        tick();

        for (int i = 0; i < 3000; i++) begin
            ex_valid   = ($urandom_range(0, 3) != 0);
            ex_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
            ex_wb_en   = ($urandom_range(0, 4) != 0);
            ex_is_load = $urandom_range(0, 1) != 0;
            ex_funct3  = 3'($urandom_range(0, 7));
            ex_result  = $urandom;
            mem_rdata  = $urandom;
            kill       = ($urandom_range(0, 9) == 0);
            reset      = ($urandom_range(0, 99) == 0);
            id_rs1     = 5'($urandom_range(0, 7));
            id_rs2     = 5'($urandom_range(0, 7));
            sample();
            tick();
        end
        reset = 1'b0; kill = 1'b0; idle();
        sample();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_wb_stage.md
# rv32i_wb_stage

Two-stage memory/writeback pipeline that sits directly upstream of the register file. It accepts one instruction per cycle from the execute stage and aligns and sign-extends load data from the synchronous data memory. It drives the register file's writeback port (wb_enable, wb_reg, wb_data). It also provides forwarding, load-use hazard and retired-instruction information to the decode/execute stages.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- ex_valid  in  1  execute-stage bundle valid this cycle.
- ex_rd  in  5  destination register.
- ex_wb_en  in  1  instruction writes rd.
- ex_is_load  in  1  instruction is a load; ex_result is the effective address.
- ex_funct3  in  3  load width/sign code.
- ex_result  in  32  ALU result, or load address.
- mem_rdata  in  32  data-memory word; valid the cycle after the address was presented.
- kill  in  1  invalidate the instruction currently in stage M.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in decode.
- fwd_valid  out  1  stage M holds a forwardable non-load result.
- fwd_rd  out  5  stage M destination register.
- fwd_data  out  32  stage M result.
- load_use_hazard  out  1  decode must stall one cycle.
- wb_enable  out  1  to register file.
- wb_reg  out  5  to register file.
- wb_data  out  32  to register file.
- misalign_err  out  1  one-cycle pulse: stage W dropped a faulting load.
- instret  out  64  retired-instruction count.

## Operation
- Stage M registers are m_valid, m_rd, m_wb_en, m_is_load, m_funct3 and m_result.
  - They load from the ex_* inputs every cycle.
  - m_valid <= ex_valid & !reset.
- kill clears m_valid at the next edge for the instruction already in M. The incoming ex_* bundle is still captured normally.
- Load extraction is combinational in M, using byte lane m_result[1:0]:
  - 000 LB: sign-extend rdata byte[lane].
  - 100 LBU: zero-extend rdata byte[lane].
  - 001 LH: sign-extend rdata half[lane[1]]; requires lane[0]=0.
  - 101 LHU: zero-extend rdata half[lane[1]]; requires lane[0]=0.
  - 010 LW: full word; requires lane=00.
  - 011, 110, 111: illegal.
  - Little-endian: byte k = rdata[8k+7:8k].
- Fault = m_valid & m_is_load & (misaligned | illegal funct3).
- Result selection: non-loads use m_result; loads use the extracted data.
- Stage W registers, updated at the same edge from stage M:
  - wb_enable <= m_valid & !kill & m_wb_en & (m_rd != 0) & !fault.
  - wb_reg <= m_rd.
  - wb_data <= the selected result.
  - misalign_err <= m_valid & !kill & fault.
- A write to x0 is never asserted on wb_enable. It still retires.
- instret increments by 1 at each edge where m_valid & !kill & !fault. It wraps from 2^64-1 to 0.
- fwd_valid = m_valid & m_wb_en & !m_is_load & (m_rd != 0). fwd_rd = m_rd, fwd_data = m_result. Combinational.
- load_use_hazard = m_valid & m_is_load & m_wb_en & (m_rd != 0) & ((m_rd == id_rs1) | (m_rd == id_rs2)). Combinational; not gated by kill.
- Because the register file reads asynchronously, its write lands only at the end of the W cycle. Consumers bypass from wb_reg/wb_data in that cycle; this block does no W-stage bypass internally.

## Timing
- Reset values: m_valid=0, wb_enable=0, wb_reg=0, wb_data=0, misalign_err=0, instret=0.
  - Derived outputs fwd_valid and load_use_hazard are therefore 0.
  - Reset overrides kill and ex_valid.
- Reset asserted mid-flight discards the M and W contents at that edge. No write occurs in the following cycle.
- Latency: ex_valid sampled at edge N; mem_rdata must be valid during cycle N+1; wb_* are valid during cycle N+2 for exactly one cycle.
- Throughput: one instruction per cycle, back-to-back, with no bubbles required.
- instret reflects an instruction in the same cycle its wb_* outputs appear.
- kill and a fault on the same instruction: kill wins, so misalign_err stays 0.

## Test plan
- LB at address 0x...3 with mem_rdata=0x80FF_1234 -> wb_data=0xFFFF_FF80 two cycles after ex_valid; LBU at the same address gives 0x0000_0080.
- LHU at address 0x...2 with rdata=0xBEEF_0000 -> wb_data=0x0000_BEEF; LH at the same address gives 0xFFFF_BEEF.
- LW at address 0x...1 -> wb_enable=0, misalign_err=1 for one cycle, instret unchanged; funct3=011 behaves the same way.
- ALU write to rd=0 -> wb_enable=0, instret +1, fwd_valid=0. Back-to-back ALU writes to x5 then x6 -> wb_enable high on two consecutive cycles, each with the correct reg/data.
- Load to x7 in M with id_rs2=7 -> load_use_hazard=1. The same case with kill asserted -> hazard still 1, next-cycle wb_enable=0, instret unchanged.
- Reset asserted while two instructions are in flight -> wb_enable, misalign_err and instret all 0 the next cycle. The first ex_valid after reset produces a write two cycles later.
